// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers (reduction polynomial 0x11B).
// Multipliers work on precomputed x1/x2/x4/x8 terms so the pipeline can register them.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  localparam int BYTE_W  = 8;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef struct packed {
    logic [7:0] x8;
    logic [7:0] x4;
    logic [7:0] x2;
    logic [7:0] x1;
  } byte_terms_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_terms_t byte_terms(input logic [7:0] a);
    byte_terms_t t;
    t.x1 = a;
    t.x2 = xtime(a);
    t.x4 = xtime(t.x2);
    t.x8 = xtime(t.x4);
    return t;
  endfunction

  function automatic logic [7:0] gf_mul09(input byte_terms_t t);
    return t.x8 ^ t.x1;
  endfunction

  function automatic logic [7:0] gf_mul0b(input byte_terms_t t);
    return t.x8 ^ t.x2 ^ t.x1;
  endfunction

  function automatic logic [7:0] gf_mul0d(input byte_terms_t t);
    return t.x8 ^ t.x4 ^ t.x1;
  endfunction

  function automatic logic [7:0] gf_mul0e(input byte_terms_t t);
    return t.x8 ^ t.x4 ^ t.x2;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns of one column, fed with the x1/x2/x4/x8 terms
// of its four bytes (byte 0 in the top 32 bits of i_terms).
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [127:0] i_terms,
  output logic [31:0]  o_col
);

  byte_terms_t w_a0;
  byte_terms_t w_a1;
  byte_terms_t w_a2;
  byte_terms_t w_a3;

  assign w_a0 = i_terms[127:96];
  assign w_a1 = i_terms[95:64];
  assign w_a2 = i_terms[63:32];
  assign w_a3 = i_terms[31:0];

  assign o_col[31:24] = gf_mul0e(w_a0) ^ gf_mul0b(w_a1) ^ gf_mul0d(w_a2) ^ gf_mul09(w_a3);
  assign o_col[23:16] = gf_mul09(w_a0) ^ gf_mul0e(w_a1) ^ gf_mul0b(w_a2) ^ gf_mul0d(w_a3);
  assign o_col[15:8]  = gf_mul0d(w_a0) ^ gf_mul09(w_a1) ^ gf_mul0e(w_a2) ^ gf_mul0b(w_a3);
  assign o_col[7:0]   = gf_mul0b(w_a0) ^ gf_mul0d(w_a1) ^ gf_mul09(w_a2) ^ gf_mul0e(w_a3);

endmodule

// File: rtl/inv_mix_columns.sv
// Registered AES InvMixColumns on a 128-bit state with valid tracking.
// Define INV_MIX_PIPE2_EN for a two-stage pipeline (latency 2) instead of one stage.
module inv_mix_columns
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] in,
  output logic         out_valid,
  output logic [127:0] out
);

  logic [4*STATE_W-1:0] w_terms;
  logic [4*STATE_W-1:0] w_mix_terms;
  logic                 w_mix_valid;
  logic [STATE_W-1:0]   w_mixed;
  logic [STATE_W-1:0]   r_out;
  logic                 r_out_valid;

  // Byte b (column b/4, row b%4) expands to a 32-bit term group at the same relative position.
  for (genvar g_b = 0; g_b < 16; g_b++) begin : g_byte
    assign w_terms[4*STATE_W-1-COL_W*g_b -: COL_W] = byte_terms(in[STATE_W-1-BYTE_W*g_b -: BYTE_W]);
  end

`ifdef INV_MIX_PIPE2_EN
  logic [4*STATE_W-1:0] r_terms;
  logic                 r_terms_valid;

  // Stage 1: capture the per-byte products and their valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_terms       <= {(4*STATE_W){1'b0}};
      r_terms_valid <= 1'b0;
    end else begin
      r_terms_valid <= in_valid;
      if (in_valid) begin
        r_terms <= w_terms;
      end
    end
  end

  assign w_mix_terms = r_terms;
  assign w_mix_valid = r_terms_valid;
`else
  assign w_mix_terms = w_terms;
  assign w_mix_valid = in_valid;
`endif

  for (genvar g_c = 0; g_c < 4; g_c++) begin : g_col
    inv_mix_column u_col (
      .i_terms (w_mix_terms[4*STATE_W-1-4*COL_W*g_c -: 4*COL_W]),
      .o_col   (w_mixed[STATE_W-1-COL_W*g_c -: COL_W])
    );
  end

  // Output stage: load a new result only when valid, otherwise hold the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= {STATE_W{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_mix_valid;
      if (w_mix_valid) begin
        r_out <= w_mixed;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed-vector bench for inv_mix_columns; latency follows INV_MIX_PIPE2_EN.
module tb_inv_mix_columns;

`ifdef INV_MIX_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         out_valid;
  logic [127:0] out_state;

  int n_vec;
  int n_err;

  inv_mix_columns dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in_state),
    .out_valid (out_valid),
    .out       (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Single isolated transaction, checked after the pipeline latency.
  task automatic run_vec(input string tag, input logic [127:0] st, input logic [127:0] ex);
    @(negedge clk);
    in_state = st;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_state = ~st;
    repeat (LAT - 1) @(negedge clk);
    chk({tag, "_vld"}, {127'd0, out_valid}, 128'd1);
    chk(tag, out_state, ex);
  endtask

  logic [127:0] st_tab [6];
  logic [127:0] ex_tab [6];

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_state = 128'h0;

    st_tab[0] = 128'h046681E5E0CB199A48F8D37A2806264C;
    ex_tab[0] = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
    st_tab[1] = 128'h8E4DA1BC9FDC589D4D7EBDF8D5D5D7D6;
    ex_tab[1] = 128'hDB135345F20A225C2D26314CD4D4D4D5;
    st_tab[2] = 128'hD5D5D7D64D7EBDF89FDC589D8E4DA1BC;
    ex_tab[2] = 128'hD4D4D4D52D26314CF20A225CDB135345;
    st_tab[3] = 128'h01010101C6C6C6C68E4DA1BC00000000;
    ex_tab[3] = 128'h01010101C6C6C6C6DB13534500000000;
    st_tab[4] = 128'h9FDC589D9FDC589D9FDC589D9FDC589D;
    ex_tab[4] = 128'hF20A225CF20A225CF20A225CF20A225C;
    st_tab[5] = 128'h4D7EBDF84D7EBDF84D7EBDF84D7EBDF8;
    ex_tab[5] = 128'h2D26314C2D26314C2D26314C2D26314C;

    repeat (3) @(negedge clk);
    chk("rst_out", out_state, 128'h0);
    chk("rst_vld", {127'd0, out_valid}, 128'd0);
    rst_n = 1'b1;

    run_vec("full_state", 128'h046681E5E0CB199A48F8D37A2806264C, 128'hD4BF5D30E0B452AEB84111F11E2798E5);
    run_vec("col_8e4d",   128'h8E4DA1BC8E4DA1BC8E4DA1BC8E4DA1BC, 128'hDB135345DB135345DB135345DB135345);
    run_vec("col_9fdc",   128'h9FDC589D9FDC589D9FDC589D9FDC589D, 128'hF20A225CF20A225CF20A225CF20A225C);
    run_vec("col_4d7e",   128'h4D7EBDF84D7EBDF84D7EBDF84D7EBDF8, 128'h2D26314C2D26314C2D26314C2D26314C);
    run_vec("col_d5d5",   128'hD5D5D7D6D5D5D7D6D5D5D7D6D5D5D7D6, 128'hD4D4D4D5D4D4D4D5D4D4D4D5D4D4D4D5);
    run_vec("fix_01",     128'h01010101010101010101010101010101, 128'h01010101010101010101010101010101);
    run_vec("fix_c6",     128'hC6C6C6C6C6C6C6C6C6C6C6C6C6C6C6C6, 128'hC6C6C6C6C6C6C6C6C6C6C6C6C6C6C6C6);
    run_vec("zero",       128'h0, 128'h0);

    // One more cycle with in_valid low: valid drops, data holds.
    @(negedge clk);
    chk("idle_vld", {127'd0, out_valid}, 128'd0);
    chk("idle_hold", out_state, 128'h0);

    // Back-to-back stream, then a gap.
    for (int i = 0; i <= 6 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT && i < 6 + LAT) begin
        chk($sformatf("strm%0d_vld", i - LAT), {127'd0, out_valid}, 128'd1);
        chk($sformatf("strm%0d", i - LAT), out_state, ex_tab[i - LAT]);
      end else if (i == 6 + LAT) begin
        chk("gap_vld", {127'd0, out_valid}, 128'd0);
        chk("gap_hold", out_state, ex_tab[5]);
      end
      if (i < 6) begin
        in_state = st_tab[i];
        in_valid = 1'b1;
      end else begin
        in_state = 128'h0;
        in_valid = 1'b0;
      end
    end

    // Reset asserted mid-cycle while a new state is in flight.
    @(negedge clk);
    in_state = st_tab[0];
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", out_state, 128'h0);
    chk("async_rst_vld", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_vld", i), {127'd0, out_valid}, 128'd0);
      chk($sformatf("post_rst%0d_out", i), out_state, 128'h0);
    end

    run_vec("after_rst", st_tab[1], ex_tab[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
